coherence_event_gen: RTL
========================

Name: coherence_event_gen

Overview:
- Upstream stage of the per-sector cache coherence FSM.
- Holds a per-line coherence state table. Accepts CPU requests and bus snoops, then classifies each one against the table.
- Either completes the access locally, or loads the line's state into the coherence FSM and drives exactly one event (RMS/RME/WM/WH/SHR/SHW) until the FSM settles.
- Writes the FSM's settled new_state back into the table.

Parameters:
- IDX_W, 4, line index width; table depth 2**IDX_W.
- TIMEOUT, 255, maximum RUN cycles spent waiting in a transient state before the line is forced INVALID.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cpu_valid  in  1  CPU request valid.
- cpu_ready  out  1  CPU request accepted this cycle.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_idx  in  IDX_W  CPU line index.
- cpu_shared_hint  in  1  another cache holds the line; selects RMS over RME.
- snp_valid  in  1  snoop valid.
- snp_ready  out  1  snoop accepted this cycle.
- snp_write  in  1  snoop is a write.
- snp_idx  in  IDX_W  snoop line index.
- fsm_load  out  1  drives the FSM's reset, loading fsm_state.
- fsm_state  out  3  state loaded into the FSM.
- fsm_new_state  in  3  FSM registered new_state.
- RMS, RME, WM, WH, SHR, SHW  out  1 each  event to the FSM; at most one high at a time.
- done  out  1  one-cycle pulse when a transaction retires.
- done_state  out  3  state written for the retired line.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- State codes:
  - Stable: INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3.
  - Transient: FILL=4, WRITE_BACK=5, WAIT_INV=6.
  - Code 7 is unused; if read from the FSM it is treated as transient.
- Reset:
  - Table cleared to INVALID; engine to IDLE.
  - All outputs 0, except cpu_ready=snp_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation abandons the transaction: no done, no table write.
- Engine states: IDLE, LOAD, RUN.
- IDLE accept rules:
  - Snoop has priority: snp_ready=1; cpu_ready = ~snp_valid.
  - Snoop to an INVALID line: retired in place. done pulses next cycle, done_state=0, no event.
  - CPU read to S/E/M: retired locally. done pulses next cycle with the unchanged state, no event.
  - CPU write to M: retired locally. done pulses next cycle, done_state=3, no event.
  - All other accepts: latch idx and event, then go to LOAD.
- Event selection:
  - CPU read to INVALID -> RME; RMS if cpu_shared_hint.
  - CPU write to INVALID -> WM.
  - CPU write to S or E -> WH.
  - Snoop read -> SHR.
  - Snoop write -> SHW.
- LOAD (1 cycle):
  - fsm_load=1, fsm_state=table[idx], events 0.
  - cpu_ready=snp_ready=0 in LOAD and RUN; no back-to-back overlap.
- RUN:
  - RUN cycle 1: the latched event is asserted; fsm_new_state is ignored.
  - RUN cycle 2 onward: event stays asserted; fsm_new_state is sampled each cycle.
  - Stable value (0..3): write it to table[idx], deassert the event, pulse done with done_state = that value, go IDLE.
  - Transient value: stay in RUN and increment the watchdog.
- Watchdog:
  - When the counter reaches TIMEOUT, table[idx]=INVALID, timeout_err=1, done=1 with done_state=0, go IDLE.
  - Counter clears on every LOAD.
- Fixed per-path latency:
  - Local retire: done one cycle after acceptance.
  - FSM path: accept, LOAD, RUN1, RUN2; done no earlier than RUN2, i.e. 3 cycles after acceptance.
- Same idx on CPU and snoop in one cycle: the snoop wins; the CPU request stays pending with cpu_ready=0.

Test Plan:
- Reset, then CPU read idx 3, hint=0:
  - LOAD with fsm_state=0, then RME held.
  - FSM model returns 4, 4, then 2.
  - done with done_state=2; table[3]=2.
- Line 5 in E, snoop read idx 5:
  - Accepted; SHR asserted from RUN1 to RUN2.
  - FSM returns 1; table[5]=1; done 3 cycles after accept.
- Line 7 in M, CPU write idx 7: done next cycle, done_state=3, no fsm_load, no event.
- Snoop and CPU both valid on idx 2, line I: snp_ready=1, cpu_ready=0; snoop retires locally with done_state=0; the CPU request is accepted the cycle after.
- TIMEOUT=8, FSM held at 6 for 20 cycles: timeout_err after 8 RUN cycles, table[idx]=0, engine IDLE.
- Reset asserted during RUN: table all 0, no done, events 0, cpu_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/coherence_event_gen.sv
// coherence_event_gen: classifies CPU requests and snoops against a per-line state table and drives one coherence FSM event per transaction.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module coherence_event_gen #(
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_write,
  input  logic [IDX_W-1:0] cpu_idx,
  input  logic             cpu_shared_hint,
  input  logic             snp_valid,
  output logic             snp_ready,
  input  logic             snp_write,
  input  logic [IDX_W-1:0] snp_idx,
  output logic             fsm_load,
  output logic [2:0]       fsm_state,
  input  logic [2:0]       fsm_new_state,
  output logic             RMS,
  output logic             RME,
  output logic             WM,
  output logic             WH,
  output logic             SHR,
  output logic             SHW,
  output logic             done,
  output logic [2:0]       done_state,
  output logic             timeout_err
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_INVALID  = 3'd0;
  localparam logic [2:0] ST_MODIFIED = 3'd3;

  // One-hot event vector, bit order {SHW, SHR, WH, WM, RME, RMS}
  localparam logic [5:0] EV_RMS = 6'b000001;
  localparam logic [5:0] EV_RME = 6'b000010;
  localparam logic [5:0] EV_WM  = 6'b000100;
  localparam logic [5:0] EV_WH  = 6'b001000;
  localparam logic [5:0] EV_SHR = 6'b010000;
  localparam logic [5:0] EV_SHW = 6'b100000;

  typedef enum logic [1:0] {ENG_IDLE, ENG_LOAD, ENG_RUN} eng_t;

  eng_t              state;
  logic [2:0]        table_q [DEPTH];
  logic [IDX_W-1:0]  idx_q;
  logic [5:0]        evt_pend;
  logic [5:0]        evt_out;
  logic              first_run;
  logic [CNT_W-1:0]  wd_cnt;
  logic              local_done;
  logic [2:0]        local_state;
  logic              fsm_load_q;
  logic [2:0]        fsm_state_q;

  logic              snp_acc;
  logic              cpu_acc;
  logic              acc_go;
  logic              acc_local;
  logic [IDX_W-1:0]  acc_idx;
  logic [5:0]        acc_evt;
  logic [2:0]        acc_lstate;
  logic [2:0]        snp_line;
  logic [2:0]        cpu_line;
  logic              sampling;
  logic              run_retire;
  logic              run_timeout;

  assign snp_ready = (state == ENG_IDLE) && !reset;
  assign cpu_ready = snp_ready && !snp_valid;
  assign snp_acc   = snp_valid && snp_ready;
  assign cpu_acc   = cpu_valid && cpu_ready;
  assign snp_line  = table_q[snp_idx];
  assign cpu_line  = table_q[cpu_idx];

  always_comb begin
    acc_go     = 1'b0;
    acc_local  = 1'b0;
    acc_idx    = '0;
    acc_evt    = '0;
    acc_lstate = ST_INVALID;
    if (snp_acc) begin
      acc_idx = snp_idx;
      if (snp_line == ST_INVALID) begin
        acc_local = 1'b1;
      end else begin
        acc_go  = 1'b1;
        acc_evt = snp_write ? EV_SHW : EV_SHR;
      end
    end else if (cpu_acc) begin
      acc_idx = cpu_idx;
      if (!cpu_write && cpu_line != ST_INVALID) begin
        acc_local  = 1'b1;
        acc_lstate = cpu_line;
      end else if (cpu_write && cpu_line == ST_MODIFIED) begin
        acc_local  = 1'b1;
        acc_lstate = ST_MODIFIED;
      end else begin
        acc_go = 1'b1;
        if (!cpu_write)
          acc_evt = cpu_shared_hint ? EV_RMS : EV_RME;
        else
          acc_evt = (cpu_line == ST_INVALID) ? EV_WM : EV_WH;
      end
    end
  end

  // The FSM's answer is only trusted from the second RUN cycle; code 7 counts as transient.
  assign sampling    = (state == ENG_RUN) && !first_run && !reset;
  assign run_retire  = sampling && !fsm_new_state[2];
  assign run_timeout = sampling && fsm_new_state[2] && (wd_cnt == CNT_W'(TIMEOUT));

  assign done        = local_done || run_retire || run_timeout;
  assign done_state  = run_retire  ? fsm_new_state :
                       run_timeout ? ST_INVALID    :
                       local_done  ? local_state   : ST_INVALID;
  assign timeout_err = run_timeout;

  assign fsm_load  = fsm_load_q;
  assign fsm_state = fsm_state_q;
  assign {SHW, SHR, WH, WM, RME, RMS} = evt_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ENG_IDLE;
      idx_q       <= '0;
      evt_pend    <= '0;
      evt_out     <= '0;
      first_run   <= 1'b0;
      wd_cnt      <= '0;
      local_done  <= 1'b0;
      local_state <= ST_INVALID;
      fsm_load_q  <= 1'b0;
      fsm_state_q <= ST_INVALID;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= ST_INVALID;
    end else begin
      local_done  <= 1'b0;
      fsm_load_q  <= 1'b0;
      fsm_state_q <= ST_INVALID;
      case (state)
        ENG_IDLE: begin
          if (acc_local) begin
            local_done  <= 1'b1;
            local_state <= acc_lstate;
          end
          if (acc_go) begin
            idx_q       <= acc_idx;
            evt_pend    <= acc_evt;
            fsm_load_q  <= 1'b1;
            fsm_state_q <= table_q[acc_idx];
            state       <= ENG_LOAD;
          end
        end
        ENG_LOAD: begin
          evt_out   <= evt_pend;
          first_run <= 1'b1;
          wd_cnt    <= '0;
          state     <= ENG_RUN;
        end
        ENG_RUN: begin
          first_run <= 1'b0;
          if (run_retire) begin
            table_q[idx_q] <= fsm_new_state;
            evt_out        <= '0;
            state          <= ENG_IDLE;
          end else if (run_timeout) begin
            table_q[idx_q] <= ST_INVALID;
            evt_out        <= '0;
            state          <= ENG_IDLE;
          end else begin
            // Counts every RUN cycle spent waiting, so expiry lands on RUN cycle TIMEOUT+1.
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ENG_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
